// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - stage count and (k, j) layer schedule for the bitonic sorter
package bitonic_pkg;

    typedef struct packed {
        logic [31:0] k;
        logic [31:0] j;
    } layer_jk_t;

    function automatic int stage_count(input int depth);
        int l;
        l = $clog2(depth);
        return l * (l + 1) / 2;
    endfunction

    // Walks the k/j schedule in network order and returns the pair for one layer.
    function automatic layer_jk_t layer_jk(input int layer, input int depth);
        layer_jk_t r;
        int idx;
        r = '0;
        idx = 0;
        for (int k = 2; k <= depth; k = k * 2) begin
            for (int j = k / 2; j >= 1; j = j / 2) begin
                if (idx == layer) begin
                    r.k = k;
                    r.j = j;
                end
                idx++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitonic_cx_layer.sv
// rtl/bitonic_cx_layer.sv - one registered compare-exchange layer of the bitonic network
module bitonic_cx_layer #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 32,
    parameter int TAG_W = 4,
    parameter int K     = 2,
    parameter int J     = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   in_valid,
    input  logic                                   in_desc,
    input  logic [DEPTH-1:0][KEY_W+TAG_W-1:0]      in_elem,
    output logic                                   out_valid,
    output logic                                   out_desc,
    output logic [DEPTH-1:0][KEY_W+TAG_W-1:0]      out_elem
);

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [TAG_W-1:0] tag;
    } elem_t;

    elem_t [DEPTH-1:0] elem_q, elem_d;
    logic              valid_q, valid_d;
    logic              desc_q, desc_d;
    elem_t             lo, hi;
    logic              asc;

    always_comb begin
        valid_d = valid_q;
        desc_d  = desc_q;
        elem_d  = elem_q;
        lo      = '0;
        hi      = '0;
        asc     = 1'b0;
        if (en) begin
            valid_d = in_valid;
            desc_d  = in_desc;
            elem_d  = in_elem;
            // Each pair is visited once from its lower index; equal keys stay put.
            for (int i = 0; i < DEPTH; i++) begin
                if (i < (i ^ J)) begin
                    lo  = in_elem[i];
                    hi  = in_elem[i ^ J];
                    asc = ((i & K) == 0) ^ in_desc;
                    if (asc ? (lo.key > hi.key) : (lo.key < hi.key)) begin
                        elem_d[i]     = hi;
                        elem_d[i ^ J] = lo;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            desc_q  <= 1'b0;
            elem_q  <= '0;
        end else begin
            valid_q <= valid_d;
            desc_q  <= desc_d;
            elem_q  <= elem_d;
        end
    end

    assign out_valid = valid_q;
    assign out_desc  = desc_q;
    assign out_elem  = elem_q;

endmodule

// File: rtl/bitonic_sort_stream.sv
// rtl/bitonic_sort_stream.sv - pipelined bitonic sorter with tags, runtime direction and backpressure
module bitonic_sort_stream
    import bitonic_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  KEY_W  = 32,
    parameter int  TAG_W  = 4,
    localparam int STAGES = stage_count(DEPTH),
    localparam int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_desc,
    input  logic [KEY_W-1:0] in_key [DEPTH],
    input  logic [TAG_W-1:0] in_tag [DEPTH],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_desc,
    output logic [KEY_W-1:0] out_key [DEPTH],
    output logic [TAG_W-1:0] out_tag [DEPTH],
    output logic [CNT_W-1:0] in_flight
);

    localparam int EW = KEY_W + TAG_W;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [TAG_W-1:0] tag;
    } elem_t;

    logic [DEPTH-1:0][EW-1:0] st_elem  [STAGES+1];
    logic                     st_valid [STAGES+1];
    logic                     st_desc  [STAGES+1];
    elem_t [DEPTH-1:0]        tail;
    logic                     en, accept, pop;
    logic [CNT_W-1:0]         in_flight_q, in_flight_d;

    // Global stall: every layer holds whenever the output slot is full and not taken.
    assign en       = !st_valid[STAGES] || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign pop      = st_valid[STAGES] && out_ready;

    assign st_valid[0] = in_valid;
    assign st_desc[0]  = in_desc;

    for (genvar e = 0; e < DEPTH; e++) begin : g_pack
        assign st_elem[0][e] = {in_key[e], in_tag[e]};
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_layer
        localparam layer_jk_t JK = layer_jk(s, DEPTH);
        bitonic_cx_layer #(
            .DEPTH (DEPTH),
            .KEY_W (KEY_W),
            .TAG_W (TAG_W),
            .K     (int'(JK.k)),
            .J     (int'(JK.j))
        ) u_layer (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .in_valid  (st_valid[s]),
            .in_desc   (st_desc[s]),
            .in_elem   (st_elem[s]),
            .out_valid (st_valid[s+1]),
            .out_desc  (st_desc[s+1]),
            .out_elem  (st_elem[s+1])
        );
    end

    // Bubble contents never leak onto the output bus.
    always_comb begin
        tail      = st_elem[STAGES];
        out_valid = st_valid[STAGES];
        out_desc  = st_valid[STAGES] ? st_desc[STAGES] : 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            out_key[i] = st_valid[STAGES] ? tail[i].key : '0;
            out_tag[i] = st_valid[STAGES] ? tail[i].tag : '0;
        end
    end

    always_comb begin
        in_flight_d = in_flight_q;
        if (accept && !pop) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (pop && !accept) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    assign in_flight = in_flight_q;

endmodule

// File: tb/tb_bitonic_sort_stream.sv
// tb/tb_bitonic_sort_stream.sv - directed and randomised checks of the bitonic sorter
module tb_bitonic_sort_stream;

    localparam int DEPTH  = 8;
    localparam int KEY_W  = 8;
    localparam int TAG_W  = 4;
    localparam int STAGES = 6;
    localparam int CW     = $clog2(STAGES + 1);

    typedef logic [DEPTH-1:0][KEY_W-1:0] kvec_t;
    typedef logic [DEPTH-1:0][TAG_W-1:0] tvec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_desc;
    logic             out_valid, out_ready, out_desc;
    logic [KEY_W-1:0] in_key  [DEPTH];
    logic [TAG_W-1:0] in_tag  [DEPTH];
    logic [KEY_W-1:0] out_key [DEPTH];
    logic [TAG_W-1:0] out_tag [DEPTH];
    logic [CW-1:0]    in_flight;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitonic_sort_stream #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_desc   (in_desc),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_desc  (out_desc),
        .out_key   (out_key),
        .out_tag   (out_tag),
        .in_flight (in_flight)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input kvec_t k, input tvec_t t, input logic d);
        for (int i = 0; i < DEPTH; i++) begin
            in_key[i] = k[i];
            in_tag[i] = t[i];
        end
        in_desc = d;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 2) step();
    endtask

    function automatic kvec_t out_k();
        kvec_t r;
        for (int i = 0; i < DEPTH; i++) r[i] = out_key[i];
        return r;
    endfunction

    function automatic tvec_t out_t();
        tvec_t r;
        for (int i = 0; i < DEPTH; i++) r[i] = out_tag[i];
        return r;
    endfunction

    function automatic kvec_t ref_keys(input kvec_t k, input logic desc);
        kvec_t r;
        logic [KEY_W-1:0] tmp;
        r = k;
        for (int a = 0; a < DEPTH; a++) begin
            for (int b = 0; b < DEPTH - 1; b++) begin
                if (desc ? (r[b] < r[b+1]) : (r[b] > r[b+1])) begin
                    tmp    = r[b];
                    r[b]   = r[b+1];
                    r[b+1] = tmp;
                end
            end
        end
        return r;
    endfunction

    // Every output (key, tag) pair must consume a distinct input pair.
    function automatic bit pairs_ok(input kvec_t ik, input tvec_t it, input kvec_t ok, input tvec_t ot);
        bit used [DEPTH];
        bit found;
        for (int i = 0; i < DEPTH; i++) used[i] = 1'b0;
        for (int o = 0; o < DEPTH; o++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && !used[i] && ik[i] == ok[o] && it[i] == ot[o]) begin
                    used[i] = 1'b1;
                    found   = 1'b1;
                end
            end
            if (!found) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in('0, '0, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_flight !== '0) begin bad++; $display("FAIL reset_in_flight got=%0d exp=0", in_flight); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_k() !== '0 || out_t() !== '0 || out_desc !== 1'b0)
            begin bad++; $display("FAIL reset_out_data key=%h tag=%h desc=%b exp=0", out_k(), out_t(), out_desc); end
        out_ready = 1'b1;
    endtask

    task automatic test_reverse_asc();
        kvec_t k, ek;
        tvec_t t, et;
        int lat;
        for (int i = 0; i < DEPTH; i++) begin
            k[i]  = KEY_W'(7 - i);
            t[i]  = TAG_W'(i);
            ek[i] = KEY_W'(i);
            et[i] = TAG_W'(7 - i);
        end
        out_ready = 1'b1;
        set_in(k, t, 1'b0);
        in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rev_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
        total++; if (lat !== STAGES) begin bad++; $display("FAIL rev_latency got=%0d exp=%0d", lat, STAGES); end
        total++; if (out_k() !== ek) begin bad++; $display("FAIL rev_keys got=%h exp=%h", out_k(), ek); end
        total++; if (out_t() !== et) begin bad++; $display("FAIL rev_tags got=%h exp=%h", out_t(), et); end
        total++; if (out_desc !== 1'b0) begin bad++; $display("FAIL rev_desc got=%b exp=0", out_desc); end
        drain();
    endtask

    task automatic test_desc_dups();
        kvec_t k, ek;
        tvec_t t;
        int lat;
        k  = {8'd5, 8'd5, 8'd0, 8'd9, 8'd1, 8'd3, 8'd9, 8'd3};
        ek = {8'd0, 8'd1, 8'd3, 8'd3, 8'd5, 8'd5, 8'd9, 8'd9};
        for (int i = 0; i < DEPTH; i++) t[i] = TAG_W'(i);
        set_in(k, t, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
        total++; if (lat !== STAGES) begin bad++; $display("FAIL dup_latency got=%0d exp=%0d", lat, STAGES); end
        total++; if (out_k() !== ek) begin bad++; $display("FAIL dup_keys got=%h exp=%h", out_k(), ek); end
        total++; if (!pairs_ok(k, t, out_k(), out_t())) begin bad++; $display("FAIL dup_pairs keys=%h tags=%h in_tags=%h", out_k(), out_t(), t); end
        total++; if (out_desc !== 1'b1) begin bad++; $display("FAIL dup_desc got=%b exp=1", out_desc); end
        drain();
    endtask

    task automatic test_back_to_back();
        kvec_t vk [6];
        tvec_t vt [6];
        kvec_t ek;
        int peak = 0;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                vk[n][i] = KEY_W'(n * 37 + i * 53);
                vt[n][i] = TAG_W'(i);
            end
        end
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            set_in(vk[n], vt[n], n[0]);
            in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready vec=%0d got=%b exp=1", n, in_ready); end
            step();
            if (int'(in_flight) > peak) peak = int'(in_flight);
        end
        in_valid = 1'b0;
        total++; if (peak !== STAGES) begin bad++; $display("FAIL b2b_peak got=%0d exp=%0d", peak, STAGES); end
        for (int n = 0; n < 6; n++) begin
            ek = ref_keys(vk[n], n[0]);
            total++; if (out_valid !== 1'b1 || out_desc !== n[0])
                begin bad++; $display("FAIL b2b_valid_desc vec=%0d valid=%b desc=%b exp_desc=%b", n, out_valid, out_desc, n[0]); end
            total++; if (out_k() !== ek) begin bad++; $display("FAIL b2b_keys vec=%0d got=%h exp=%h", n, out_k(), ek); end
            total++; if (!pairs_ok(vk[n], vt[n], out_k(), out_t())) begin bad++; $display("FAIL b2b_pairs vec=%0d tags=%h", n, out_t()); end
            step();
        end
        drain();
    endtask

    task automatic test_backpressure();
        kvec_t vk [10];
        kvec_t ek [10];
        tvec_t vt [10];
        logic  vd [10];
        int sent = 0, got = 0, stall = 0, cyc = 0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                vk[n][i] = KEY_W'(n * 29 + i * 83 + 5);
                vt[n][i] = TAG_W'(15 - i);
            end
            vd[n] = (n % 3 == 0);
            ek[n] = ref_keys(vk[n], vd[n]);
        end
        while (got < 10 && cyc < 300) begin
            in_valid = (sent < 10);
            if (sent < 10) set_in(vk[sent], vt[sent], vd[sent]);
            out_ready = !(out_valid && got == 0 && stall < 5);
            @(negedge clk);
            if (!out_ready) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                total++; if (out_k() !== ek[0] || out_desc !== vd[0])
                    begin bad++; $display("FAIL bp_hold cyc=%0d key=%h exp=%h desc=%b", cyc, out_k(), ek[0], out_desc); end
                stall++;
            end
            if (out_valid && out_ready) begin
                total++;
                if (out_k() !== ek[got] || out_desc !== vd[got] || !pairs_ok(vk[got], vt[got], out_k(), out_t()))
                    begin bad++; $display("FAIL bp_vec vec=%0d key=%h exp=%h desc=%b exp_desc=%b", got, out_k(), ek[got], out_desc, vd[got]); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++; if (got !== 10 || stall !== 5) begin bad++; $display("FAIL bp_count got=%0d exp=10 stalls=%0d exp=5", got, stall); end
        total++; if (in_flight !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained in_flight=%0d valid=%b exp=0", in_flight, out_valid); end
        drain();
    endtask

    task automatic test_reset_midflight();
        kvec_t k;
        tvec_t t;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                k[i] = KEY_W'(n * 11 + i * 7);
                t[i] = TAG_W'(i);
            end
            set_in(k, t, n[0]);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        total++; if (in_flight !== CW'(3)) begin bad++; $display("FAIL rstm_pre got=%0d exp=3", in_flight); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++; if (out_valid !== 1'b0 || in_flight !== '0)
                begin bad++; $display("FAIL rstm_quiet cyc=%0d valid=%b in_flight=%0d exp=0", c, out_valid, in_flight); end
            step();
        end
    endtask

    task automatic test_random();
        kvec_t qk [$];
        tvec_t qt [$];
        logic  qd [$];
        kvec_t k, ik, ek;
        tvec_t t, it;
        logic  d, id;
        int sent = 0, got = 0, cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < DEPTH; i++) begin
                k[i] = ($urandom_range(0, 1) != 0) ? KEY_W'($urandom_range(0, 7)) : KEY_W'($urandom);
                t[i] = TAG_W'($urandom);
            end
            d = 1'($urandom_range(0, 1));
            set_in(k, t, d);
            @(negedge clk);
            total++; if (in_flight !== CW'(qk.size()) || int'(in_flight) > STAGES)
                begin bad++; $display("FAIL rnd_in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, qk.size()); end
            if (out_valid && out_ready) begin
                total++;
                if (qk.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious cyc=%0d got=valid exp=idle", cyc);
                end else begin
                    ik = qk.pop_front();
                    it = qt.pop_front();
                    id = qd.pop_front();
                    ek = ref_keys(ik, id);
                    if (out_k() !== ek || out_desc !== id || !pairs_ok(ik, it, out_k(), out_t()))
                        begin bad++; $display("FAIL rnd_vec n=%0d key=%h exp=%h desc=%b exp_desc=%b", got, out_k(), ek, out_desc, id); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                qk.push_back(k);
                qt.push_back(t);
                qd.push_back(d);
                sent++;
            end
            step();
            cyc++;
        end
        total++; if (got !== 1000) begin bad++; $display("FAIL rnd_count got=%0d exp=1000", got); end
        drain();
    endtask

    initial begin
        test_reset();
        test_reverse_asc();
        test_desc_dups();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
